// File: rtl/divider_core_n_if.sv
// divider_core_n handshake and result bundle.
// Driver side uses master, the divider core uses slave.
interface divider_core_n_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic             Ack;
   logic [WIDTH-1:0] Xin;
   logic [WIDTH-1:0] Yin;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Done;
   logic             Qi;
   logic             Qc;
   logic             Qd;
   logic             DivByZero;
   logic [WIDTH:0]   Cycles;

   modport master (
      output Start, Ack, Xin, Yin,
      input  Quotient, Remainder, Done,
      input  Qi, Qc, Qd, DivByZero, Cycles
   );

   modport slave (
      input  Start, Ack, Xin, Yin,
      output Quotient, Remainder, Done,
      output Qi, Qc, Qd, DivByZero, Cycles
   );
endinterface

// File: rtl/divider_core_n.sv
// Parametrised unsigned divider, QI/QC/QD handshake.
// MODE 0: repetitive subtraction, MODE 1: restoring shift-subtract.
module divider_core_n #(
   parameter int WIDTH = 8,
   parameter int MODE  = 0
) (
   input logic              Clk,
   input logic              Reset,
   divider_core_n_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] QI = 2'b00;
   localparam logic [1:0] QC = 2'b01;
   localparam logic [1:0] QD = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH:0]   cyc_q, cyc_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] sq_q, sq_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   t_w;
   logic             ge_w;

   // next-state and datapath for all three states
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      cyc_d   = cyc_q;
      r_d     = r_q;
      sq_d    = sq_q;
      cnt_d   = cnt_q;
      t_w     = {r_q[WIDTH-1:0], sq_q[WIDTH-1]};
      ge_w    = (t_w >= {1'b0, y_q});
      case (state_q)
         QI: begin
            x_d    = bus.Xin;
            y_d    = bus.Yin;
            quot_d = '0;
            dbz_d  = 1'b0;
            r_d    = '0;
            sq_d   = bus.Xin;
            cnt_d  = '0;
            if (bus.Start) begin
               state_d = QC;
               cyc_d   = '0;
            end
         end
         QC: begin
            cyc_d = cyc_q + 1'b1;
            if (y_q == '0) begin
               quot_d  = '1;
               rem_d   = x_q;
               dbz_d   = 1'b1;
               state_d = QD;
            end else if (MODE == 0) begin
               if (x_q >= y_q) begin
                  x_d    = x_q - y_q;
                  quot_d = quot_q + 1'b1;
               end else begin
                  rem_d   = x_q;
                  state_d = QD;
               end
            end else begin
               if (ge_w) begin
                  r_d  = t_w - {1'b0, y_q};
                  sq_d = {sq_q[WIDTH-2:0], 1'b1};
               end else begin
                  r_d  = t_w;
                  sq_d = {sq_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quot_d  = sq_d;
                  rem_d   = r_d[WIDTH-1:0];
                  state_d = QD;
               end
            end
         end
         QD: begin
            if (bus.Ack) begin
               state_d = QI;
            end
         end
         default: state_d = QI;
      endcase
   end

   // state and datapath registers, async active-low clear
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= QI;
         x_q     <= '0;
         y_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         cyc_q   <= '0;
         r_q     <= '0;
         sq_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         cyc_q   <= cyc_d;
         r_q     <= r_d;
         sq_q    <= sq_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Quotient  = quot_q;
   assign bus.Remainder = rem_q;
   assign bus.DivByZero = dbz_q;
   assign bus.Cycles    = cyc_q;
   assign bus.Qi        = (state_q == QI);
   assign bus.Qc        = (state_q == QC);
   assign bus.Qd        = (state_q == QD);
   assign bus.Done      = (state_q == QD);
endmodule

// File: tb/tb_divider_core_n.sv
// Scoreboard bench for divider_core_n: three instances
// (8-bit subtract, 8-bit restoring, 16-bit restoring).
module tb_divider_core_n;
   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic [16:0] cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t e0, e1, e2;
   logic pd0, pd1, pd2;

   divider_core_n_if #(.WIDTH(8))  b0();
   divider_core_n_if #(.WIDTH(8))  b1();
   divider_core_n_if #(.WIDTH(16)) b2();

   divider_core_n #(.WIDTH(8), .MODE(0)) u0 (
      .Clk(clk), .Reset(rst_n), .bus(b0)
   );
   divider_core_n #(.WIDTH(8), .MODE(1)) u1 (
      .Clk(clk), .Reset(rst_n), .bus(b1)
   );
   divider_core_n #(.WIDTH(16), .MODE(1)) u2 (
      .Clk(clk), .Reset(rst_n), .bus(b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // reference: plain unsigned division with the divide-by-zero rule
   function automatic exp_t model(input int w, input int mode,
                                  input logic [15:0] x,
                                  input logic [15:0] y);
      exp_t   e;
      longint mask;
      longint xv;
      longint yv;
      mask = (longint'(1) << w) - 1;
      xv   = longint'(x) & mask;
      yv   = longint'(y) & mask;
      if (yv == 0) begin
         e.q   = 16'(mask);
         e.r   = 16'(xv);
         e.dbz = 1'b1;
         e.cyc = 17'd1;
      end else begin
         e.q   = 16'(xv / yv);
         e.r   = 16'(xv % yv);
         e.dbz = 1'b0;
         e.cyc = (mode == 1) ? 17'(w) : 17'(xv / yv + 1);
      end
      return e;
   endfunction

   function automatic exp_t model_k(input int k, input logic [15:0] x,
                                    input logic [15:0] y);
      if (k == 0) return model(8, 0, x, y);
      if (k == 1) return model(8, 1, x, y);
      return model(16, 1, x, y);
   endfunction

   task automatic push(input int k, input logic [15:0] x,
                       input logic [15:0] y);
      if (k == 0) q0.push_back(model_k(k, x, y));
      else if (k == 1) q1.push_back(model_k(k, x, y));
      else q2.push_back(model_k(k, x, y));
   endtask

   task automatic drv(input int k, input logic s, input logic a,
                      input logic [15:0] x, input logic [15:0] y);
      if (k == 0) begin
         b0.Start = s; b0.Ack = a; b0.Xin = x[7:0]; b0.Yin = y[7:0];
      end else if (k == 1) begin
         b1.Start = s; b1.Ack = a; b1.Xin = x[7:0]; b1.Yin = y[7:0];
      end else begin
         b2.Start = s; b2.Ack = a; b2.Xin = x; b2.Yin = y;
      end
   endtask

   function automatic logic get_done(input int k);
      if (k == 0) return b0.Done;
      if (k == 1) return b1.Done;
      return b2.Done;
   endfunction

   function automatic logic get_qi(input int k);
      if (k == 0) return b0.Qi;
      if (k == 1) return b1.Qi;
      return b2.Qi;
   endfunction

   function automatic logic get_qc(input int k);
      if (k == 0) return b0.Qc;
      if (k == 1) return b1.Qc;
      return b2.Qc;
   endfunction

   task automatic wait_done(input int k);
      int n;
      n = 0;
      while (!get_done(k) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!get_done(k)) begin
         checks++;
         errors++;
         $display("FAIL timeout u%0d: Done not seen within %0d cycles",
                  k, n);
      end
   endtask

   task automatic release_ack(input int k, input logic [15:0] x,
                              input logic [15:0] y);
      repeat (2) @(negedge clk);
      chk($sformatf("u%0d done hold", k), longint'(get_done(k)), 1);
      drv(k, 1'b0, 1'b1, x, y);
      @(negedge clk);
      drv(k, 1'b0, 1'b0, x, y);
      chk($sformatf("u%0d qi after ack", k), longint'(get_qi(k)), 1);
   endtask

   // one full operation; both=1 raises Ack with Start, chx changes Xin in QC
   task automatic do_op(input int k, input logic [15:0] x,
                        input logic [15:0] y, input logic both,
                        input logic chx);
      @(negedge clk);
      drv(k, 1'b1, both, x, y);
      push(k, x, y);
      @(negedge clk);
      if (both)
         chk($sformatf("u%0d start+ack qc", k), longint'(get_qc(k)), 1);
      drv(k, 1'b0, 1'b0, chx ? 16'(x ^ 16'hA5C3) : x, y);
      wait_done(k);
      release_ack(k, x, y);
   endtask

   // monitors: compare every fresh Done against the queue head
   always @(negedge clk) begin
      if (b0.Done && !pd0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0 unexpected: Done with empty queue");
         end else begin
            e0 = q0.pop_front();
            chk("u0 quotient", longint'(b0.Quotient), longint'(e0.q));
            chk("u0 remainder", longint'(b0.Remainder), longint'(e0.r));
            chk("u0 dbz", longint'(b0.DivByZero), longint'(e0.dbz));
            chk("u0 cycles", longint'(b0.Cycles), longint'(e0.cyc));
         end
      end
      pd0 = b0.Done;
   end

   always @(negedge clk) begin
      if (b1.Done && !pd1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1 unexpected: Done with empty queue");
         end else begin
            e1 = q1.pop_front();
            chk("u1 quotient", longint'(b1.Quotient), longint'(e1.q));
            chk("u1 remainder", longint'(b1.Remainder), longint'(e1.r));
            chk("u1 dbz", longint'(b1.DivByZero), longint'(e1.dbz));
            chk("u1 cycles", longint'(b1.Cycles), longint'(e1.cyc));
         end
      end
      pd1 = b1.Done;
   end

   always @(negedge clk) begin
      if (b2.Done && !pd2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL u2 unexpected: Done with empty queue");
         end else begin
            e2 = q2.pop_front();
            chk("u2 quotient", longint'(b2.Quotient), longint'(e2.q));
            chk("u2 remainder", longint'(b2.Remainder), longint'(e2.r));
            chk("u2 dbz", longint'(b2.DivByZero), longint'(e2.dbz));
            chk("u2 cycles", longint'(b2.Cycles), longint'(e2.cyc));
         end
      end
      pd2 = b2.Done;
   end

   initial begin
      logic [15:0] x;
      logic [15:0] y;
      checks = 0;
      errors = 0;
      pd0 = 1'b0; pd1 = 1'b0; pd2 = 1'b0;
      rst_n = 1'b0;
      drv(0, 1'b0, 1'b0, 16'd0, 16'd0);
      drv(1, 1'b0, 1'b0, 16'd0, 16'd0);
      drv(2, 1'b0, 1'b0, 16'd0, 16'd0);
      repeat (3) @(negedge clk);

      chk("rst qi", longint'(b0.Qi), 1);
      chk("rst qc", longint'(b0.Qc), 0);
      chk("rst qd", longint'(b1.Qd), 0);
      chk("rst done", longint'(b2.Done), 0);
      chk("rst quotient", longint'(b0.Quotient), 0);
      chk("rst remainder", longint'(b1.Remainder), 0);
      chk("rst dbz", longint'(b2.DivByZero), 0);
      chk("rst cycles", longint'(b0.Cycles), 0);
      rst_n = 1'b1;

      do_op(0, 16'd200, 16'd7, 1'b0, 1'b0);
      do_op(1, 16'd200, 16'd7, 1'b0, 1'b0);
      do_op(1, 16'd255, 16'd1, 1'b0, 1'b0);
      do_op(0, 16'h5A, 16'd0, 1'b0, 1'b0);
      do_op(1, 16'h5A, 16'd0, 1'b0, 1'b0);
      do_op(0, 16'd3, 16'd9, 1'b0, 1'b0);
      do_op(0, 16'd255, 16'd1, 1'b0, 1'b0);
      do_op(2, 16'd65535, 16'd256, 1'b0, 1'b0);
      do_op(2, 16'd65535, 16'd256, 1'b0, 1'b1);
      do_op(1, 16'd77, 16'd5, 1'b1, 1'b0);

      // Start held: second operation launches one cycle after QD exits
      @(negedge clk);
      drv(1, 1'b1, 1'b0, 16'd199, 16'd13);
      push(1, 16'd199, 16'd13);
      @(negedge clk);
      drv(1, 1'b1, 1'b0, 16'd250, 16'd3);
      push(1, 16'd250, 16'd3);
      wait_done(1);
      @(negedge clk);
      drv(1, 1'b1, 1'b1, 16'd250, 16'd3);
      @(negedge clk);
      chk("held qi one cycle", longint'(b1.Qi), 1);
      @(negedge clk);
      chk("held relaunch qc", longint'(b1.Qc), 1);
      drv(1, 1'b0, 1'b0, 16'd250, 16'd3);
      wait_done(1);
      release_ack(1, 16'd250, 16'd3);

      // reset on the 5th QC cycle aborts the long operation
      @(negedge clk);
      drv(0, 1'b1, 1'b0, 16'd255, 16'd1);
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 16'd255, 16'd1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort qi", longint'(b0.Qi), 1);
      chk("abort quotient", longint'(b0.Quotient), 0);
      chk("abort cycles", longint'(b0.Cycles), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < 3; k++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) y = 16'd0;
            else if (k < 2 && $urandom_range(0, 1) == 1)
               y = 16'($urandom_range(1, 15));
            do_op(k, x, y, 1'($urandom_range(0, 1)), 1'b1);
         end
      end

      repeat (2) @(negedge clk);
      chk("u0 queue drained", longint'(q0.size()), 0);
      chk("u1 queue drained", longint'(q1.size()), 0);
      chk("u2 queue drained", longint'(q2.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
